// File: rtl/johnson_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl_if
//   Command handshake between the pin-level command decode and the Johnson
//   counter sequencer.
//
//   cmd_valid  command present (master -> slave)
//   cmd_ready  command accepted when cmd_valid && cmd_ready (slave -> master)
//   cmd_op     00 STOP, 01 RUN, 10 SET_DIV, 11 CLEAR
//   cmd_dir    RUN direction: 0 shift up, 1 shift down
//   cmd_arg    RUN: step count (0 = free-run); SET_DIV: divider value
// ---------------------------------------------------------------------------
interface johnson_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [7:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_dir,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_dir,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
//   Command-driven sequencer for an 8-bit Johnson counter. Issues registered
//   shift / direction / clear strobes paced by a programmable prescaler,
//   runs a bounded step count or free-runs, and mirrors the counter position
//   in a 4-bit phase value.
//
//   Parameters
//     DIV_W     prescaler divider width (shift period = div+1 clocks)
//     CNT_W     step-count width
//
//   Ports
//     clk       system clock
//     rst_n     asynchronous reset, ACTIVE-HIGH despite the name
//     cmd       command handshake (johnson_seq_ctrl_if.slave)
//     jc_q      current counter value (only used by the illegal-code check)
//     jc_shift  one-cycle shift strobe to the counter
//     jc_dir    direction qualifying jc_shift
//     jc_clear  one-cycle synchronous clear strobe to the counter
//     phase     mirror of counter position, 0..15
//     busy      high while running
//     done      one-cycle pulse one cycle after the last bounded shift
//     err       sticky illegal-code flag
//
//   Optional feature (macro JSC_ILLEGAL_CHECK_EN)
//     When defined, jc_q is checked every cycle against the 16 legal Johnson
//     codes; an illegal value sets err and forces a clear pass, overriding
//     any command in that cycle. When undefined, jc_q is ignored and err = 0.
// ---------------------------------------------------------------------------
module johnson_seq_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    johnson_seq_ctrl_if.slave   cmd,
    input  logic [7:0]          jc_q,
    output logic                jc_shift,
    output logic                jc_dir,
    output logic                jc_clear,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        CLR  = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_STOP    = 2'b00,
        OP_RUN     = 2'b01,
        OP_SET_DIV = 2'b10,
        OP_CLEAR   = 2'b11
    } op_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div, div_d;
    logic [DIV_W-1:0]   pre_cnt, pre_d;
    logic [CNT_W-1:0]   remaining, rem_d;
    logic               free_run, free_d;
    logic               dir_d;
    logic [3:0]         phase_d;
    logic               shift_d;
    logic               accept;
    logic               clear_cmd;
    logic               force_clr;
    op_t                op;

    assign op            = op_t'(cmd.cmd_op);
    assign cmd.cmd_ready = (state == IDLE) || (state == RUN);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef JSC_ILLEGAL_CHECK_EN
    logic err_d;

    // Legal Johnson codes are a contiguous run of ones filled from the LSB
    // (00,01,03..FF) or their complements (FF,FE,FC..00).
    function automatic logic is_johnson(input logic [7:0] v);
        logic       ok;
        logic [8:0] m9;
        ok = 1'b0;
        for (int unsigned k = 0; k <= 8; k++) begin
            m9 = (9'd1 << k) - 9'd1;
            if ((v == m9[7:0]) || (v == ~m9[7:0])) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    // The check is skipped while in CLR so the forced pass stays one cycle.
    assign force_clr = (state != CLR) && !is_johnson(jc_q);
`else
    logic unused_jc_q;

    assign unused_jc_q = ^jc_q;
    assign force_clr   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state / datapath decisions
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        div_d     = div;
        pre_d     = pre_cnt;
        rem_d     = remaining;
        free_d    = free_run;
        dir_d     = jc_dir;
        phase_d   = phase;
        shift_d   = 1'b0;
        clear_cmd = 1'b0;

        if (force_clr) begin
            state_d = CLR;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (accept && (op == OP_RUN)) begin
                        // Restart in RUN keeps phase; only the pacing resets.
                        dir_d   = cmd.cmd_dir;
                        rem_d   = CNT_W'(cmd.cmd_arg);
                        free_d  = (cmd.cmd_arg == 8'd0);
                        pre_d   = '0;
                        state_d = RUN;
                    end else if (accept && (op == OP_CLEAR)) begin
                        clear_cmd = 1'b1;
                        state_d   = CLR;
                    end else if (accept && (op == OP_STOP)) begin
                        state_d = IDLE;
                    end else begin
                        if (accept && (op == OP_SET_DIV)) begin
                            div_d = DIV_W'(cmd.cmd_arg);
                        end
                        // Compare uses the divider held this cycle, so a
                        // SET_DIV only affects the following compares and
                        // pre_cnt simply wraps if it is already past it.
                        if (state == RUN) begin
                            if (pre_cnt == div) begin
                                shift_d = 1'b1;
                                pre_d   = '0;
                                phase_d = jc_dir ? (phase - 4'd1) : (phase + 4'd1);
                                if (!free_run) begin
                                    rem_d = remaining - CNT_W'(1);
                                    if (remaining == CNT_W'(1)) begin
                                        state_d = DONE;
                                    end
                                end
                            end else begin
                                pre_d = pre_cnt + DIV_W'(1);
                            end
                        end
                    end
                end
                CLR:     state_d = IDLE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Phase and step count are zeroed on entry to CLR, coinciding with
        // the jc_clear strobe.
        if (state_d == CLR) begin
            phase_d = '0;
            rem_d   = '0;
            pre_d   = '0;
        end
    end

`ifdef JSC_ILLEGAL_CHECK_EN
    always_comb begin
        err_d = err;
        if (force_clr) begin
            err_d = 1'b1;
        end else if (clear_cmd) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            div       <= '0;
            pre_cnt   <= '0;
            remaining <= '0;
            free_run  <= 1'b0;
            jc_dir    <= 1'b0;
            phase     <= '0;
            jc_shift  <= 1'b0;
            jc_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            div       <= div_d;
            pre_cnt   <= pre_d;
            remaining <= rem_d;
            free_run  <= free_d;
            jc_dir    <= dir_d;
            phase     <= phase_d;
            jc_shift  <= shift_d;
            jc_clear  <= (state_d == CLR);
            busy      <= (state_d == RUN);
            // DONE is entered on the last shift edge, so done lands one
            // cycle after the final jc_shift.
            done      <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_ctrl
//   Directed bench for johnson_seq_ctrl. Expected strobe events (cycle,
//   phase, direction) are queued when commands are issued and matched as the
//   DUT emits jc_shift / done / jc_clear. Build with JSC_ILLEGAL_CHECK_EN to
//   cover the illegal-code path.
// ---------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] ph;
        logic       dir;
    } shift_ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] jc_q;
    logic       jc_shift, jc_dir, jc_clear, busy, done, err;
    logic [3:0] phase;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shift_ev_t shq[$];
    int        dnq[$];
    int        clq[$];

    johnson_seq_ctrl_if bus ();

    johnson_seq_ctrl #(
        .DIV_W (8),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (bus),
        .jc_q     (jc_q),
        .jc_shift (jc_shift),
        .jc_dir   (jc_dir),
        .jc_clear (jc_clear),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_shift(input int c, input logic [3:0] p, input logic d);
        shift_ev_t e;
        e.cyc = c;
        e.ph  = p;
        e.dir = d;
        shq.push_back(e);
    endtask

    task automatic send(input logic [1:0] op, input logic dir, input logic [7:0] arg,
                        output int acc);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_send", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dir   = dir;
        bus.cmd_arg   = arg;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        check({tag, "_shift_q_empty"}, shq.size(), 0);
        check({tag, "_done_q_empty"}, dnq.size(), 0);
        check({tag, "_clear_q_empty"}, clq.size(), 0);
        shq.delete();
        dnq.delete();
        clq.delete();
    endtask

    // Output monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (jc_shift) begin
                if (shq.size() == 0) begin
                    check("spurious_shift", jc_shift, 0);
                end else begin
                    shift_ev_t e;
                    e = shq.pop_front();
                    check("shift_cycle", cyc, e.cyc);
                    check("shift_phase", phase, e.ph);
                    check("shift_dir", jc_dir, e.dir);
                end
            end
            if (done) begin
                if (dnq.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    check("done_cycle", cyc, dnq.pop_front());
                end
            end
            if (jc_clear) begin
                if (clq.size() == 0) begin
                    check("spurious_clear", jc_clear, 0);
                end else begin
                    check("clear_cycle", cyc, clq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a, c, tmp;
        logic [3:0] p;

        rst_n         = 1'b1;
        jc_q          = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_dir   = 1'b0;
        bus.cmd_arg   = 8'h00;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_shift", jc_shift, 0);
        check("rst_dir", jc_dir, 0);
        check("rst_clear", jc_clear, 0);
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", bus.cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b0;

        // ---- bounded run: div=3, 4 steps up ----
        send(2'b10, 1'b0, 8'd3, tmp);
        send(2'b01, 1'b0, 8'd4, a);
        for (int k = 1; k <= 4; k++) push_shift(a + 4 * k, 4'(k), 1'b0);
        dnq.push_back(a + 17);
        check("t1_busy_run", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t1_busy_after", busy, 0);
        check("t1_phase_end", phase, 4);
        drain("t1");

        // ---- clear, then free run at div=0 down, stop after 20 strobes ----
        send(2'b11, 1'b0, 8'd0, c);
        clq.push_back(c);
        check("t2_phase_cleared", phase, 0);
        send(2'b10, 1'b0, 8'd0, tmp);
        send(2'b01, 1'b1, 8'd0, a);
        p = 4'd0;
        for (int k = 1; k <= 20; k++) begin
            p = p - 4'd1;
            push_shift(a + k, p, 1'b1);
        end
        repeat (20) @(posedge clk);
        send(2'b00, 1'b0, 8'd0, tmp);
        check("t2_stop_edge", tmp, a + 21);
        repeat (3) @(posedge clk);
        #1;
        check("t2_phase_end", phase, 12);
        check("t2_busy_after", busy, 0);
        drain("t2");

        // ---- run 10 at div=1, clear after 3 strobes ----
        send(2'b10, 1'b0, 8'd1, tmp);
        send(2'b01, 1'b0, 8'd10, a);
        push_shift(a + 2, 4'd13, 1'b0);
        push_shift(a + 4, 4'd14, 1'b0);
        push_shift(a + 6, 4'd15, 1'b0);
        repeat (6) @(posedge clk);
        send(2'b11, 1'b0, 8'd0, c);
        clq.push_back(c);
        check("t3_ready_low", bus.cmd_ready, 0);
        check("t3_phase_zero", phase, 0);
        check("t3_busy_low", busy, 0);
        @(posedge clk);
        #1;
        check("t3_ready_back", bus.cmd_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        drain("t3");

        // ---- SET_DIV 1 during RUN with div=7 at pre_cnt=2 ----
        send(2'b10, 1'b0, 8'd7, tmp);
        send(2'b01, 1'b0, 8'd0, a);
        repeat (2) @(posedge clk);
        send(2'b10, 1'b0, 8'd1, tmp);
        check("t4_setdiv_edge", tmp, a + 3);
        push_shift(a + 258, 4'd1, 1'b0);
        push_shift(a + 260, 4'd2, 1'b0);
        push_shift(a + 262, 4'd3, 1'b0);
        repeat (259) @(posedge clk);
        send(2'b00, 1'b0, 8'd0, tmp);
        repeat (3) @(posedge clk);
        #1;
        check("t4_phase_end", phase, 3);
        drain("t4");

        // ---- asynchronous reset mid-run at pre_cnt=5 ----
        send(2'b10, 1'b0, 8'd9, tmp);
        send(2'b01, 1'b1, 8'd0, a);
        repeat (5) @(posedge clk);
        #1;
        check("t5_busy_pre", busy, 1);
        check("t5_dir_pre", jc_dir, 1);
        #2;
        rst_n = 1'b1;
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_dir", jc_dir, 0);
        check("t5_async_phase", phase, 0);
        check("t5_async_shift", jc_shift, 0);
        check("t5_async_clear", jc_clear, 0);
        check("t5_async_done", done, 0);
        check("t5_async_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        check("t5_ready_idle", bus.cmd_ready, 1);
        send(2'b01, 1'b0, 8'd2, a);
        push_shift(a + 1, 4'd1, 1'b0);
        push_shift(a + 2, 4'd2, 1'b0);
        dnq.push_back(a + 3);
        repeat (5) @(posedge clk);
        #1;
        check("t5_busy_after", busy, 0);
        drain("t5");

        // ---- illegal counter code ----
`ifdef JSC_ILLEGAL_CHECK_EN
        send(2'b10, 1'b0, 8'd3, tmp);
        send(2'b01, 1'b0, 8'd0, a);
        @(negedge clk);
        jc_q = 8'h05;
        @(posedge clk);
        #1;
        c = cyc;
        jc_q = 8'h00;
        clq.push_back(c);
        check("t6_err_set", err, 1);
        check("t6_phase_zero", phase, 0);
        check("t6_busy_low", busy, 0);
        @(posedge clk);
        #1;
        check("t6_ready_idle", bus.cmd_ready, 1);
        check("t6_err_sticky", err, 1);
        send(2'b11, 1'b0, 8'd0, c);
        clq.push_back(c);
        check("t6_err_cleared", err, 0);
        repeat (3) @(posedge clk);
        #1;
        drain("t6");
`else
        @(negedge clk);
        jc_q = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        check("t6_err_ignored", err, 0);
        check("t6_no_clear", jc_clear, 0);
        jc_q = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        drain("t6");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
